pipe_hazard_unit: RTL and testbench

Parametrised interlock and forwarding controller for the in-order MIPS pipeline. It generalises the fixed EX/MEM/WB hazard and forwarding logic to DEPTH post-decode stages and per-instruction result latency. It tracks every in-flight register writer in a valid-tagged shift register and produces decode stall, bubble insertion, and operand-forwarding selects for both decode-time users (branch, jr) and EX-time users. It sits beside the decode stage and drives the ID/EX register enable and the operand muxes.

---
 rtl/pipe_hazard_unit.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Interlock and operand-forwarding controller for DEPTH post-decode stages with per-instruction
// result latency. Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned LAT_W  = 2,
    localparam int unsigned SEL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_early,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              id_kill,
    input  logic              ex_kill,
    output logic              id_ready,
    output logic              stall,
    output logic [SEL_W-1:0]  id_fwd_a,
    output logic [SEL_W-1:0]  id_fwd_b,
    output logic [SEL_W-1:0]  ex_fwd_a,
    output logic [SEL_W-1:0]  ex_fwd_b,
    output logic [DEPTH-1:0]  stg_valid,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       kill_cnt
);

    logic [DEPTH-1:0]             v_q;
    logic [DEPTH-1:0]             we_q;
    logic [DEPTH-1:0][REG_AW-1:0] rg_q;
    logic [DEPTH-1:0][LAT_W-1:0]  lat_q;
    logic [SEL_W-1:0]             ex_fwd_a_q, ex_fwd_b_q;

    logic [1:0]                   op_use;
    logic [1:0][REG_AW-1:0]       op_idx;
    logic [1:0]                   hz;
    logic [1:0][SEL_W-1:0]        id_sel, ex_sel;
    logic [LAT_W-1:0]             wr_lat;
    logic                         accept;

    assign op_use = {id_use_rt, id_use_rs};
    assign op_idx = {id_rt, id_rs};
    assign wr_lat = (id_lat == '0) ? LAT_W'(1) : id_lat;

    // Youngest matching producer decides; stage 0 is invisible while it is being killed.
    always_comb begin
        logic        hit;
        int unsigned s, l;
        hz     = '0;
        id_sel = '0;
        ex_sel = '0;
        hit    = 1'b0;
        s      = 0;
        l      = 1;
        for (int op = 0; op < 2; op++) begin
            hit = 1'b0;
            s   = 0;
            l   = 1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!hit && op_use[op] && (op_idx[op] != '0) && v_q[i] && we_q[i] &&
                    (rg_q[i] == op_idx[op]) && !(i == 0 && ex_kill)) begin
                    hit = 1'b1;
                    s   = i;
                    l   = 32'(lat_q[i]);
                end
            end
            if (hit) begin
                if (id_early) begin
                    if (s < l) begin
                        hz[op] = 1'b1;
                    end else if (s != DEPTH - 1) begin
                        // The last stage writes through the register file, so select 0 there.
                        id_sel[op] = SEL_W'(s + 1);
                    end
                end else begin
                    if (s + 1 < l) begin
                        hz[op] = 1'b1;
                    end else if (s + 1 < DEPTH) begin
                        ex_sel[op] = SEL_W'(s + 2);
                    end
                end
            end
        end
    end

    assign stall     = id_valid & ~id_kill & (|hz);
    assign id_ready  = ~stall;
    assign accept    = id_valid & ~stall & ~id_kill;
    assign id_fwd_a  = id_sel[0];
    assign id_fwd_b  = id_sel[1];
    assign ex_fwd_a  = ex_fwd_a_q;
    assign ex_fwd_b  = ex_fwd_b_q;
    assign stg_valid = v_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q        <= '0;
            we_q       <= '0;
            rg_q       <= '0;
            lat_q      <= '0;
            ex_fwd_a_q <= '0;
            ex_fwd_b_q <= '0;
        end else begin
            v_q        <= {v_q[DEPTH-2:0], accept};
            v_q[1]     <= v_q[0] & ~ex_kill;
            we_q       <= {we_q[DEPTH-2:0], id_wr_en};
            rg_q       <= {rg_q[DEPTH-2:0], id_wr_reg};
            lat_q      <= {lat_q[DEPTH-2:0], wr_lat};
            ex_fwd_a_q <= accept ? ex_sel[0] : '0;
            ex_fwd_b_q <= accept ? ex_sel[1] : '0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, kill_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (id_kill | ex_kill) kill_cnt_q <= kill_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`else
    assign stall_cnt = '0;
    assign kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: an age-tagged list of in-flight writers predicts every output each
// cycle, while directed sequences pin known stall/forwarding results.
module tb_pipe_hazard_unit;

    localparam int REG_AW = 5;
    localparam int DEPTH  = 3;
    localparam int LAT_W  = 2;
    localparam int SEL_W  = 2;

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt;
    logic              id_use_rs, id_use_rt;
    logic              id_early;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_reg;
    logic [LAT_W-1:0]  id_lat;
    logic              id_kill, ex_kill;
    logic              id_ready, stall;
    logic [SEL_W-1:0]  id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b;
    logic [DEPTH-1:0]  stg_valid;
    logic [31:0]       stall_cnt, kill_cnt;

    pipe_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_early(id_early),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_lat(id_lat), .id_kill(id_kill),
        .ex_kill(ex_kill), .id_ready(id_ready), .stall(stall), .id_fwd_a(id_fwd_a),
        .id_fwd_b(id_fwd_b), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .stg_valid(stg_valid), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit we;
        int rg;
        int lat;
        int age;
    } rec_t;

    rec_t        inflight[$];
    rec_t        nq[$];
    int          total = 0;
    int          bad = 0;
    bit          started = 0;
    int          m_ex_a = 0, m_ex_b = 0;
    logic [31:0] m_stall_cnt = 0, m_kill_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Operand resolution from the rules: find the youngest writer, compare its age with latency.
    function automatic void eval_op(input bit use_b, input int idx, input bit early,
                                    output bit hz, output int idsel, output int exsel);
        int age, lat;
        age = -1;
        lat = 1;
        hz = 0; idsel = 0; exsel = 0;
        if (!use_b || idx == 0) return;
        foreach (inflight[i]) begin
            if (inflight[i].we && inflight[i].rg == idx && !(inflight[i].age == 0 && ex_kill) &&
                (age < 0 || inflight[i].age < age)) begin
                age = inflight[i].age;
                lat = (inflight[i].lat == 0) ? 1 : inflight[i].lat;
            end
        end
        if (age < 0) return;
        if (early) begin
            if (age < lat) hz = 1;
            else idsel = (age == DEPTH - 1) ? 0 : age + 1;
        end else begin
            if (age + 1 < lat) hz = 1;
            else exsel = (age + 1 >= DEPTH) ? 0 : age + 2;
        end
    endfunction

    function automatic void eval_all(output bit e_stall, output int ia, output int ib,
                                     output int xa, output int xb, output bit acc);
        bit ha, hb;
        eval_op(id_use_rs, int'(id_rs), id_early, ha, ia, xa);
        eval_op(id_use_rt, int'(id_rt), id_early, hb, ib, xb);
        e_stall = id_valid && !id_kill && (ha || hb);
        acc     = id_valid && !e_stall && !id_kill;
    endfunction

    always @(posedge clk) begin
        bit st, acc;
        int ia, ib, xa, xb;
        rec_t r;
        if (reset) begin
            inflight.delete();
            m_ex_a = 0; m_ex_b = 0;
            m_stall_cnt = 0; m_kill_cnt = 0;
        end else begin
            eval_all(st, ia, ib, xa, xb, acc);
`ifdef PIPE_PERF_CNT_EN
            if (st) m_stall_cnt = m_stall_cnt + 1;
            if (id_kill || ex_kill) m_kill_cnt = m_kill_cnt + 1;
`endif
            nq.delete();
            foreach (inflight[i]) begin
                r = inflight[i];
                if (!(r.age == 0 && ex_kill) && r.age + 1 < DEPTH) begin
                    r.age = r.age + 1;
                    nq.push_back(r);
                end
            end
            inflight = nq;
            if (acc) begin
                r.we = id_wr_en; r.rg = int'(id_wr_reg); r.lat = int'(id_lat); r.age = 0;
                inflight.push_back(r);
            end
            m_ex_a = acc ? xa : 0;
            m_ex_b = acc ? xb : 0;
        end
        started = 1;
    end

    always @(negedge clk) begin
        bit st, acc;
        int ia, ib, xa, xb;
        logic [31:0] mask;
        if (started) begin
            eval_all(st, ia, ib, xa, xb, acc);
            mask = 0;
            foreach (inflight[i]) mask[inflight[i].age] = 1'b1;
            chk("stall", 32'(stall), 32'(st));
            chk("id_ready", 32'(id_ready), 32'(!st));
            chk("id_fwd_a", 32'(id_fwd_a), ia);
            chk("id_fwd_b", 32'(id_fwd_b), ib);
            chk("ex_fwd_a", 32'(ex_fwd_a), m_ex_a);
            chk("ex_fwd_b", 32'(ex_fwd_b), m_ex_b);
            chk("stg_valid", 32'(stg_valid), mask);
            chk("stall_cnt", stall_cnt, m_stall_cnt);
            chk("kill_cnt", kill_cnt, m_kill_cnt);
        end
    end

    task automatic set_idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_early = 0;
        id_wr_en = 0; id_wr_reg = 0; id_lat = 0; id_kill = 0; ex_kill = 0;
    endtask

    task automatic set_wr(input int r, input int l);
        set_idle();
        id_valid = 1; id_wr_en = 1; id_wr_reg = REG_AW'(r); id_lat = LAT_W'(l);
    endtask

    task automatic set_rd(input int r, input bit early);
        set_idle();
        id_valid = 1; id_use_rs = 1; id_rs = REG_AW'(r); id_early = early;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic fin();
        @(posedge clk); #1;
    endtask

    task automatic flush();
        set_idle();
        repeat (DEPTH + 1) fin();
    endtask

    initial begin
        reset = 1;
        set_idle();
        fin(); fin();
        reset = 0;
        mid();
        chk("lit reset stg_valid", 32'(stg_valid), 0);
        chk("lit reset stall", 32'(stall), 0);
        chk("lit reset ex_fwd_a", 32'(ex_fwd_a), 0);
        fin();

        // ALU chain
        set_wr(8, 1); fin();
        set_rd(8, 0); mid(); chk("lit alu stall", 32'(stall), 0); fin();
        set_idle(); mid(); chk("lit alu ex_fwd_a", 32'(ex_fwd_a), 2); fin();

        // Load-use
        flush();
        set_wr(9, 2); fin();
        set_rd(9, 0); mid(); chk("lit load stall", 32'(stall), 1); fin();
        mid();
        chk("lit load stall2", 32'(stall), 0);
        chk("lit load bubble", 32'(stg_valid[0]), 0);
        fin();
        set_idle(); mid(); chk("lit load ex_fwd_a", 32'(ex_fwd_a), 3); fin();

        // Early branch
        flush();
        set_wr(10, 1); fin();
        set_rd(10, 1); mid(); chk("lit br stall", 32'(stall), 1); fin();
        mid();
        chk("lit br stall2", 32'(stall), 0);
        chk("lit br id_fwd_a", 32'(id_fwd_a), 2);
        fin();

        // Zero register
        flush();
        set_wr(0, 1); fin();
        set_rd(0, 0); mid();
        chk("lit zero stall", 32'(stall), 0);
        chk("lit zero id_fwd_a", 32'(id_fwd_a), 0);
        fin();
        set_idle(); mid(); chk("lit zero ex_fwd_a", 32'(ex_fwd_a), 0); fin();

        // Priority: youngest of two writers wins
        flush();
        set_wr(8, 2); fin();
        set_wr(8, 1); fin();
        set_rd(8, 0); mid(); chk("lit prio stall", 32'(stall), 0); fin();
        set_idle(); mid(); chk("lit prio ex_fwd_a", 32'(ex_fwd_a), 2); fin();

        // ex_kill of the producer
        flush();
        set_wr(9, 2); fin();
        set_rd(9, 0); ex_kill = 1; mid();
        chk("lit exk stall", 32'(stall), 0);
        chk("lit exk id_ready", 32'(id_ready), 1);
        fin();
        set_idle(); mid();
        chk("lit exk ex_fwd_a", 32'(ex_fwd_a), 0);
        chk("lit exk stg_valid", 32'(stg_valid), 1);
        fin();

        // id_kill during a hazard
        flush();
        set_wr(9, 2); fin();
        set_rd(9, 0); id_kill = 1; mid(); chk("lit idk stall", 32'(stall), 0); fin();
        set_idle(); mid(); chk("lit idk bubble", 32'(stg_valid[0]), 0); fin();

        // Five forced stalls
        flush();
        reset = 1; fin(); reset = 0;
        set_wr(11, 3); fin();
        set_rd(11, 1); repeat (4) fin();
        set_wr(12, 3); fin();
        set_rd(12, 0); repeat (3) fin();
        set_idle(); mid();
`ifdef PIPE_PERF_CNT_EN
        chk("lit stall_cnt", stall_cnt, 5);
`else
        chk("lit stall_cnt", stall_cnt, 0);
`endif
        fin();

        // Reset in the middle of a stall
        flush();
        set_wr(13, 3); fin();
        set_rd(13, 1); mid(); chk("lit rst pre stall", 32'(stall), 1); fin();
        reset = 1; fin(); reset = 0;
        mid();
        chk("lit rst stall", 32'(stall), 0);
        chk("lit rst stg_valid", 32'(stg_valid), 0);
        chk("lit rst stall_cnt", stall_cnt, 0);
        fin();

        // Randomized traffic on a small register window to force frequent hazards
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            id_valid  = ($urandom_range(0, 3) != 0);
            id_rs     = REG_AW'($urandom_range(0, 3));
            id_rt     = REG_AW'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1));
            id_use_rt = 1'($urandom_range(0, 1));
            id_early  = ($urandom_range(0, 3) == 0);
            id_wr_en  = ($urandom_range(0, 3) != 0);
            id_wr_reg = REG_AW'($urandom_range(0, 3));
            id_lat    = LAT_W'($urandom_range(0, 3));
            id_kill   = ($urandom_range(0, 15) == 0);
            ex_kill   = ($urandom_range(0, 15) == 0);
            fin();
        end
        reset = 0;
        flush();
        mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
